// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit: HI/LO registers, fixed-latency MULT/DIV with busy
// handshake, and the md_stall hazard term that D-stage control needs.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_p, lo_p;
  logic          wr_p;

  logic          is_md;
  logic [63:0]   mul_s, mul_u;
  logic [31:0]   div_b, a_mag, b_mag, qs, rs, qu, ru;
  logic [31:0]   res_hi, res_lo;
  logic          res_wr;

  assign is_md    = start && (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
  assign md_stall = md_use && (busy || is_md);

  // Signed division works on magnitudes so 0x80000000 / -1 yields 0x80000000 rem 0
  // without overflow; a zero divisor is replaced by 1 only to keep the datapath X-free.
  always_comb begin
    mul_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    mul_u  = {32'd0, A} * {32'd0, B};
    div_b  = (B == '0) ? 32'd1 : B;
    a_mag  = A[31] ? -A : A;
    b_mag  = div_b[31] ? -div_b : div_b;
    qs     = a_mag / b_mag;
    rs     = a_mag % b_mag;
    qu     = A / div_b;
    ru     = A % div_b;
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b1;
    case (mdu_op)
      OP_MULT:  {res_hi, res_lo} = mul_s;
      OP_MULTU: {res_hi, res_lo} = mul_u;
      OP_DIV: begin
        res_lo = (A[31] ^ B[31]) ? -qs : qs;
        res_hi = A[31] ? -rs : rs;
        res_wr = (B != '0);
      end
      OP_DIVU: begin
        res_lo = qu;
        res_hi = ru;
        res_wr = (B != '0);
      end
      default: res_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
      hi_p  <= '0;
      lo_p  <= '0;
      wr_p  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            hi_p  <= res_hi;
            lo_p  <= res_lo;
            wr_p  <= res_wr;
            cnt   <= (mdu_op == OP_DIV || mdu_op == OP_DIVU) ? CW'(DIV_CYCLES - 1)
                                                             : CW'(MULT_CYCLES - 1);
            state <= RUN;
            busy  <= 1'b1;
          end else if (start && mdu_op == OP_MTHI) begin
            HI <= A;
          end else if (start && mdu_op == OP_MTLO) begin
            LO <= A;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            if (wr_p) begin
              HI <= hi_p;
              LO <= lo_p;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: table of MULT/DIV vectors plus hand-written
// sequences for MTHI/MTLO, divide-by-zero, busy-time starts, md_stall and reset.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset, start, md_use;
  logic [2:0]  mdu_op;
  logic [31:0] A, B;
  logic        busy, md_stall;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          n;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } res_t;

  res_t        sb[$];
  vec_t        tbl[10];
  logic [31:0] m_hi, m_lo;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .A(A), .B(B),
    .md_use(md_use), .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one start cycle; returns at #1 after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mdu_op = op;
    A      = a;
    B      = b;
    step();
    start  = 1'b0;
    mdu_op = 3'd0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic pop_check(input string name);
    res_t r;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got empty scoreboard expected entry", name);
    end else begin
      r = sb.pop_front();
      check({name, "_hi"}, HI, r.hi);
      check({name, "_lo"}, LO, r.lo);
      m_hi = r.hi;
      m_lo = r.lo;
    end
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                     input int n_exp);
    int n;
    sb.push_back('{hi: hi, lo: lo});
    issue(op, a, b);
    wait_done(n);
    check({name, "_cycles"}, n, n_exp);
    pop_check(name);
  endtask

  initial begin
    int n, stall_n;

    tbl[0] = '{3'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    tbl[1] = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14,       10};
    tbl[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[3] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
    tbl[4] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    tbl[5] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    tbl[6] = '{3'd1, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        5};
    tbl[7] = '{3'd4, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 10};
    tbl[8] = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    tbl[9] = '{3'd3, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       10};

    reset = 1'b1; start = 1'b0; md_use = 1'b1; mdu_op = 3'd0; A = '0; B = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_stall", md_stall, 0);
    md_use = 1'b0;
    m_hi = '0;
    m_lo = '0;

    for (int i = 0; i < 10; i++) begin
      run($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].n);
    end

    // MTHI, then divide by zero must leave HI/LO untouched.
    issue(3'd5, 32'h1234, 32'd0);
    check("mthi_busy", busy, 0);
    check("mthi_hi", HI, 32'h1234);
    m_hi = 32'h1234;
    run("divz", 3'd3, 32'd5, 32'd0, m_hi, m_lo, 10);
    run("divuz", 3'd4, 32'd9, 32'd0, m_hi, m_lo, 10);

    // MTLO held across the whole MULTU, including the completion edge.
    sb.push_back('{hi: 32'hFFFFFFFE, lo: 32'h1});
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    start = 1'b1; mdu_op = 3'd6; A = 32'h55;
    wait_done(n);
    start = 1'b0; mdu_op = 3'd0;
    check("mtlo_busy_cycles", n, 5);
    pop_check("mtlo_busy");
    step();
    check("mtlo_busy_lo_after", LO, 32'h1);

    // MULT start held across a DIVU: no restart, no corruption, no start at completion.
    sb.push_back('{hi: 32'd2, lo: 32'd14});
    issue(3'd4, 32'd100, 32'd7);
    start = 1'b1; mdu_op = 3'd1; A = 32'd3; B = 32'd3;
    wait_done(n);
    start = 1'b0; mdu_op = 3'd0;
    check("restart_cycles", n, 10);
    pop_check("restart");
    step();
    check("restart_busy_after", busy, 0);
    check("restart_hi_after", HI, 32'd2);

    // NONE and reserved op with start do nothing.
    issue(3'd0, 32'hDEAD, 32'hBEEF);
    issue(3'd7, 32'hDEAD, 32'hBEEF);
    check("none_busy", busy, 0);
    check("none_hi", HI, m_hi);
    check("none_lo", LO, m_lo);

    // md_stall covers the start cycle plus every busy cycle.
    md_use = 1'b1;
    sb.push_back('{hi: 32'd0, lo: 32'd6});
    start = 1'b1; mdu_op = 3'd1; A = 32'd2; B = 32'd3;
    #1;
    stall_n = md_stall ? 1 : 0;
    check("stall_start_cycle", md_stall, 1);
    step();
    start = 1'b0; mdu_op = 3'd0;
    n = 0;
    while (busy && n < 200) begin
      if (md_stall) stall_n++;
      n++;
      step();
    end
    check("stall_cycles", stall_n, 6);
    check("stall_after", md_stall, 0);
    pop_check("stall_mult");

    md_use = 1'b0;
    sb.push_back('{hi: 32'd0, lo: 32'd6});
    start = 1'b1; mdu_op = 3'd1; A = 32'd2; B = 32'd3;
    #1;
    stall_n = md_stall ? 1 : 0;
    step();
    start = 1'b0; mdu_op = 3'd0;
    n = 0;
    while (busy && n < 200) begin
      if (md_stall) stall_n++;
      n++;
      step();
    end
    check("nouse_stall_cycles", stall_n, 0);
    check("nouse_cycles", n, 5);
    pop_check("nouse_mult");

    // Reset three cycles into a DIV discards the pending result.
    issue(3'd4, 32'd100, 32'd7);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    check("midrst_busy", busy, 0);
    check("midrst_hi", HI, 0);
    check("midrst_lo", LO, 0);
    m_hi = '0;
    m_lo = '0;
    run("post_rst_mult", 3'd1, 32'd2, 32'd3, 32'd0, 32'd6, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
